// File: rtl/adc_resync_sched.sv
// Round-robin scheduler for per-channel DCM/ISERDES resynchronisation.
// It serves one ADC channel at a time, retries on timeout, and re-requests a channel when it loses lock.
module adc_resync_sched #(
  parameter int N_ADC     = 4,
  parameter int TIMEOUT   = 1023,
  parameter int MAX_RETRY = 3,
  parameter int LOCK_FILT = 8,
  parameter int GAP       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [N_ADC-1:0]           req,
  input  logic [N_ADC-1:0]           locked,
  input  logic [N_ADC-1:0]           rst_end,
  output logic [N_ADC-1:0]           init,
  output logic                       busy,
  output logic [N_ADC-1:0]           ready,
  output logic [N_ADC-1:0]           fail,
  output logic [$clog2(N_ADC)-1:0]   cur_ch
);

  localparam int CH_W = $clog2(N_ADC);
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam int RT_W = $clog2(MAX_RETRY + 1);
  localparam int GC_W = $clog2(GAP + 1);
  localparam int LF_W = $clog2(LOCK_FILT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t            state, state_nxt;
  logic [N_ADC-1:0]  pending;
  logic [CH_W-1:0]   ptr, sel;
  logic              sel_vld;
  logic [WC_W-1:0]   wait_cnt;
  logic [RT_W-1:0]   retry;
  logic [GC_W-1:0]   gap_cnt;
  logic [LF_W-1:0]   lock_cnt [N_ADC];
  logic [N_ADC-1:0]  lost, set_pend, cur_oh;
  logic [N_ADC-1:0]  init_nxt, ok_set, fail_set, fail_clr, clr_pend;
  logic              done, tmo, retry_last, gap_last;

  // First pending channel at or after ptr; descending scan leaves the nearest one.
  always_comb begin
    int idx;
    idx     = 0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = N_ADC - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_ADC;
      if (pending[idx]) begin
        sel     = CH_W'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    cur_oh         = '0;
    cur_oh[cur_ch] = 1'b1;
    for (int i = 0; i < N_ADC; i++)
      lost[i] = ready[i] && !locked[i] && (lock_cnt[i] == LF_W'(LOCK_FILT - 1));
    set_pend   = {N_ADC{start}} | req | lost;
    done       = (state == S_WAIT) && rst_end[cur_ch];
    tmo        = (state == S_WAIT) && !rst_end[cur_ch] && (wait_cnt == WC_W'(TIMEOUT - 1));
    retry_last = (int'(retry) + 1) >= MAX_RETRY;
    gap_last   = (gap_cnt == GC_W'(GAP - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sel_vld) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (done)     state_nxt = S_GAP;
        else if (tmo) state_nxt = retry_last ? S_GAP : S_ISSUE;
      end
      S_GAP:   if (gap_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    init_nxt = '0;
    fail_clr = '0;
    ok_set   = '0;
    fail_set = '0;
    clr_pend = '0;
    if (state == S_ISSUE) begin
      init_nxt = cur_oh;
      fail_clr = cur_oh;
    end
    if (done) begin
      clr_pend = cur_oh;
      if (locked[cur_ch]) ok_set   = cur_oh;
      else                fail_set = cur_oh;
    end
    if (tmo && retry_last) begin
      clr_pend = cur_oh;
      fail_set = cur_oh;
    end
  end

  // A new pending set always wins over a completion clearing the same channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      init     <= '0;
      busy     <= 1'b0;
      ready    <= '0;
      fail     <= '0;
      cur_ch   <= '0;
      pending  <= '0;
      ptr      <= '0;
      retry    <= '0;
      wait_cnt <= '0;
      gap_cnt  <= '0;
      for (int i = 0; i < N_ADC; i++) lock_cnt[i] <= '0;
    end else begin
      init    <= init_nxt;
      busy    <= (state_nxt != S_IDLE);
      pending <= (pending & ~clr_pend) | set_pend;
      ready   <= (ready | ok_set) & ~set_pend;
      fail    <= (fail & ~fail_clr) | fail_set;
      if (state == S_IDLE && sel_vld) begin
        cur_ch <= sel;
        ptr    <= CH_W'((int'(sel) + 1) % N_ADC);
        retry  <= '0;
      end else if (tmo) begin
        retry  <= retry + RT_W'(1);
      end
      if (state == S_ISSUE)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + WC_W'(1);
      if (state == S_GAP) gap_cnt <= gap_cnt + GC_W'(1);
      else                gap_cnt <= '0;
      for (int i = 0; i < N_ADC; i++) begin
        if (!ready[i] || locked[i] || lost[i]) lock_cnt[i] <= '0;
        else                                   lock_cnt[i] <= lock_cnt[i] + LF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adc_resync_sched.sv
// Directed bench for adc_resync_sched: ordering, latency, timeout/retry, lock loss, collisions, reset.
module tb_adc_resync_sched;

  localparam int N       = 4;
  localparam int TMO     = 32;
  localparam int RETRIES = 3;
  localparam int LFILT   = 8;
  localparam int GAPC    = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] locked = '1;
  logic [N-1:0] rst_end = '0;
  logic [N-1:0] init, ready, fail;
  logic         busy;
  logic [1:0]   cur_ch;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  adc_resync_sched #(
    .N_ADC(N), .TIMEOUT(TMO), .MAX_RETRY(RETRIES), .LOCK_FILT(LFILT), .GAP(GAPC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .req(req), .locked(locked), .rst_end(rst_end),
    .init(init), .busy(busy), .ready(ready), .fail(fail), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_init(input int budget, output int ch, output int at);
    ch = -1;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (init != '0) break;
      tick();
    end
    if (init != '0) begin
      at = cyc;
      for (int b = 0; b < N; b++) if (init[b]) ch = b;
      chk("init_onehot", $countones(init), 1);
    end
  endtask

  task automatic answer(input int ch, input int dly);
    repeat (dly) tick();
    rst_end[ch] = 1'b1;
    tick();
    rst_end = '0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      tick();
    end
    chk("idle", busy, 0);
  endtask

  initial begin
    int ch, at, prev, t0;
    logic [N-1:0] seen;

    // Reset state
    repeat (3) tick();
    chk("rst_init", init, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fail", fail, 0);
    chk("rst_cur_ch", cur_ch, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Start: channels 0..3 in order, response 20 cycles after init
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    prev = 0;
    for (int k = 0; k < N; k++) begin
      wait_init(100, ch, at);
      chk("start_order", ch, k);
      chk("start_busy", busy, 1);
      if (k == 0) chk("start_latency", at - t0, 3);
      else        chk("start_spacing", at - prev, 20 + 1 + GAPC + 2);
      prev = at;
      tick();
      chk("init_single", init, 0);
      answer(k, 19);
    end
    repeat (5) tick();
    chk("start_ready", ready, 4'b1111);
    chk("start_busy_end", busy, 0);
    chk("start_cur_ch", cur_ch, 3);

    // req 1010 from ptr 0: ch1 then ch3, ptr back to 0
    req = 4'b1010;
    tick();
    req = '0;
    chk("req_clears_ready", ready, 4'b0101);
    wait_init(20, ch, at);
    chk("req_first", ch, 1);
    answer(1, 5);
    wait_init(40, ch, at);
    chk("req_second", ch, 3);
    answer(3, 5);
    wait_idle(40);
    req = 4'b1001;
    tick();
    req = '0;
    wait_init(20, ch, at);
    chk("ptr_wrap_first", ch, 0);
    answer(0, 5);
    wait_init(40, ch, at);
    chk("ptr_wrap_second", ch, 3);
    answer(3, 5);
    wait_idle(40);
    chk("req_ready", ready, 4'b1111);

    // ch2 never answers: MAX_RETRY inits spaced TIMEOUT+1, then fail
    req = 4'b0100;
    tick();
    req = '0;
    wait_init(20, ch, prev);
    chk("tmo_ch_0", ch, 2);
    for (int r = 1; r < RETRIES; r++) begin
      tick();
      wait_init(TMO + 10, ch, at);
      chk("tmo_ch_n", ch, 2);
      chk("tmo_spacing", at - prev, TMO + 1);
      prev = at;
    end
    repeat (TMO - 1) tick();
    chk("tmo_fail_early", fail, 4'b0000);
    tick();
    chk("tmo_fail", fail, 4'b0100);
    chk("tmo_ready", ready, 4'b1011);
    chk("tmo_busy_gap", busy, 1);
    repeat (GAPC) tick();
    chk("tmo_idle", busy, 0);
    seen = '0;
    repeat (40) begin
      tick();
      seen |= init;
    end
    chk("tmo_no_reinit", seen, 0);

    // Lock loss filter on ch1: 7 low cycles ignored, 8 trigger a reissue
    locked[1] = 1'b0;
    repeat (LFILT - 1) tick();
    locked[1] = 1'b1;
    seen = '0;
    repeat (5) begin
      tick();
      seen |= init;
    end
    chk("lock7_ready", ready, 4'b1011);
    chk("lock7_no_init", seen, 0);
    locked[1] = 1'b0;
    repeat (LFILT - 1) tick();
    chk("lock8_pre", ready, 4'b1011);
    tick();
    chk("lock8_ready", ready, 4'b1001);
    locked[1] = 1'b1;
    tick();
    chk("lock8_init_wait", init, 0);
    tick();
    chk("lock8_init", init, 4'b0010);
    answer(1, 5);
    wait_idle(40);
    chk("lock8_recover", ready, 4'b1011);
    chk("lock8_fail_kept", fail, 4'b0100);

    // req[0] coincident with its completing rst_end: set wins, served again
    req = 4'b0001;
    tick();
    req = '0;
    chk("coll_clear", ready, 4'b1010);
    wait_init(20, ch, at);
    chk("coll_first", ch, 0);
    repeat (5) tick();
    req[0] = 1'b1;
    rst_end[0] = 1'b1;
    tick();
    req = '0;
    rst_end = '0;
    chk("coll_ready", ready, 4'b1010);
    wait_init(40, ch, at);
    chk("coll_second", ch, 0);
    answer(0, 3);
    wait_idle(40);
    chk("coll_final", ready, 4'b1011);

    // Reset while waiting for rst_end
    req = 4'b1000;
    tick();
    req = '0;
    wait_init(20, ch, at);
    chk("rstw_ch", ch, 3);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_init", init, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_ready", ready, 0);
    chk("rstw_fail", fail, 0);
    chk("rstw_cur_ch", cur_ch, 0);
    seen = '0;
    repeat (40) begin
      tick();
      seen |= init;
    end
    chk("rstw_no_init", seen, 0);
    req = 4'b0100;
    tick();
    req = '0;
    wait_init(20, ch, at);
    chk("rstw_new_req", ch, 2);
    answer(2, 4);
    wait_idle(40);
    chk("rstw_ready_after", ready, 4'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
